// File: rtl/bus_snoop_agent_pkg.sv
// Shared bus-op, snoop-result and FSM encodings for the snoop agent and MESIF controller.
// Line address widths come from TAG_BITS / INDEX_BITS defines.
`ifndef TAG_BITS
`define TAG_BITS 8
`endif
`ifndef INDEX_BITS
`define INDEX_BITS 4
`endif

package bus_snoop_agent_pkg;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INVAL = 3'd3;
  localparam logic [2:0] OP_RFO   = 3'd4;
  localparam logic [2:0] OP_NOP   = 3'd5;

  localparam logic [1:0] SNP_HIT   = 2'd0;
  localparam logic [1:0] SNP_HITM  = 2'd1;
  localparam logic [1:0] SNP_NOHIT = 2'd2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BCAST   = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_WB_WAIT = 3'd3;
  localparam logic [2:0] ST_RESPOND = 3'd4;

  // Unknown op codes collapse to NOP so downstream decode only sees legal values.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    return (op >= OP_READ && op <= OP_RFO) ? op : OP_NOP;
  endfunction
endpackage

// File: rtl/bus_snoop_agent_merge.sv
// snoop_merge: priority merge of masked per-agent snoop results (hitm > hit > nohit).
module snoop_merge
  import bus_snoop_agent_pkg::*;
#(
  parameter int NUM_AGENTS = 3
) (
  input  logic [NUM_AGENTS-1:0]   mask,
  input  logic [2*NUM_AGENTS-1:0] resp,
  output logic [1:0]              result
);
  logic [NUM_AGENTS-1:0] is_hitm, is_hit;

  // Reserved code 3 and unreceived agents fall through to nohit.
  for (genvar i = 0; i < NUM_AGENTS; i++) begin : g_agent
    assign is_hitm[i] = mask[i] && (resp[2*i+:2] == SNP_HITM);
    assign is_hit[i]  = mask[i] && (resp[2*i+:2] == SNP_HIT);
  end

  always_comb begin
    result = SNP_NOHIT;
    if (|is_hitm)     result = SNP_HITM;
    else if (|is_hit) result = SNP_HIT;
  end
endmodule

// File: rtl/bus_snoop_agent.sv
// Bus snoop agent: broadcasts one local bus op, merges remote snoop results, returns combined result.
// Optional SNOOP_TIMEOUT_EN forces completion after SNOOP_TIMEOUT cycles in COLLECT/WB_WAIT.
`ifndef TAG_BITS
`define TAG_BITS 8
`endif
`ifndef INDEX_BITS
`define INDEX_BITS 4
`endif

module bus_snoop_agent
  import bus_snoop_agent_pkg::*;
#(
  parameter int NUM_AGENTS    = 3,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [`TAG_BITS-1:0]    req_tag,
  input  logic [`INDEX_BITS-1:0]  req_index,
  output logic                    snp_valid,
  output logic [2:0]              snp_op,
  output logic [`TAG_BITS-1:0]    snp_tag,
  output logic [`INDEX_BITS-1:0]  snp_index,
  input  logic [NUM_AGENTS-1:0]   snp_resp_valid,
  input  logic [2*NUM_AGENTS-1:0] snp_resp,
  input  logic                    wb_valid,
  output logic                    done_valid,
  output logic [1:0]              done_snoop,
  output logic                    timeout_err
);
  logic [2:0]              state, state_nxt;
  logic [NUM_AGENTS-1:0]   mask, mask_nxt;
  logic [2*NUM_AGENTS-1:0] resp_q, resp_nxt;
  logic [1:0]              result_q, result_nxt, merged;
  logic                    tmo_q, tmo_nxt;
  logic                    capture, expired;

  // WRITE broadcasts but never collects; only first response per agent counts.
  assign capture = (state == ST_BCAST && snp_op != OP_WRITE) || state == ST_COLLECT;

  always_comb begin
    mask_nxt = mask;
    resp_nxt = resp_q;
    if (capture) begin
      for (int i = 0; i < NUM_AGENTS; i++) begin
        if (snp_resp_valid[i] && !mask[i]) begin
          mask_nxt[i]       = 1'b1;
          resp_nxt[2*i+:2]  = snp_resp[2*i+:2];
        end
      end
    end
  end

  snoop_merge #(.NUM_AGENTS(NUM_AGENTS)) u_merge (
    .mask   (mask_nxt),
    .resp   (resp_nxt),
    .result (merged)
  );

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = $clog2(SNOOP_TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // Counter reads k in the k-th cycle after entering COLLECT; fire one cycle early so RESPOND lands at k=SNOOP_TIMEOUT.
  assign expired = (state == ST_COLLECT || state == ST_WB_WAIT) && cnt == CW'(SNOOP_TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         cnt <= '0;
    else if (state == ST_BCAST)                         cnt <= '0;
    else if (state == ST_COLLECT || state == ST_WB_WAIT) cnt <= cnt + 1'b1;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    result_nxt = result_q;
    tmo_nxt    = tmo_q;
    case (state)
      ST_IDLE: if (req_valid) begin
        tmo_nxt = 1'b0;
        if (norm_op(req_op) == OP_NOP) begin
          state_nxt  = ST_RESPOND;
          result_nxt = SNP_NOHIT;
        end else begin
          state_nxt = ST_BCAST;
        end
      end
      ST_BCAST, ST_COLLECT: begin
        if (state == ST_BCAST && snp_op == OP_WRITE) begin
          state_nxt  = ST_RESPOND;
          result_nxt = SNP_NOHIT;
        end else if (&mask_nxt) begin
          // INVALIDATE takes hitm at face value; only READ/RFO need the dirty data.
          if (merged == SNP_HITM && (snp_op == OP_READ || snp_op == OP_RFO)) begin
            state_nxt = ST_WB_WAIT;
          end else begin
            state_nxt  = ST_RESPOND;
            result_nxt = merged;
          end
        end else if (expired) begin
          state_nxt  = ST_RESPOND;
          result_nxt = merged;
          tmo_nxt    = 1'b1;
        end else begin
          state_nxt = ST_COLLECT;
        end
      end
      ST_WB_WAIT: if (wb_valid || expired) begin
        state_nxt  = ST_RESPOND;
        result_nxt = SNP_HITM;
        tmo_nxt    = !wb_valid;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mask      <= '0;
      resp_q    <= '0;
      result_q  <= SNP_NOHIT;
      tmo_q     <= 1'b0;
      snp_op    <= OP_NOP;
      snp_tag   <= '0;
      snp_index <= '0;
    end else begin
      state    <= state_nxt;
      result_q <= result_nxt;
      tmo_q    <= tmo_nxt;
      if (state == ST_RESPOND) begin
        mask   <= '0;
        resp_q <= '0;
      end else begin
        mask   <= mask_nxt;
        resp_q <= resp_nxt;
      end
      if (state == ST_IDLE && req_valid) begin
        snp_op    <= norm_op(req_op);
        snp_tag   <= req_tag;
        snp_index <= req_index;
      end
    end
  end

  assign req_ready   = (state == ST_IDLE);
  assign snp_valid   = (state == ST_BCAST);
  assign done_valid  = (state == ST_RESPOND);
  assign done_snoop  = result_q;
  assign timeout_err = (state == ST_RESPOND) && tmo_q;
endmodule

// File: doc/bus_snoop_agent.md
# bus_snoop_agent

Bus-side counterpart of the per-line MESIF controller. It accepts one bus operation at a time from the local cache (READ, WRITE, INVALIDATE, RFO, NOP) and broadcasts it to NUM_AGENTS remote caches. It collects and merges their snoop results, waits for a dirty-owner writeback when required, and returns the combined snoop result that the MESIF controller consumes as its in_snoop input.

## Interface
- NUM_AGENTS, 3: number of remote snooping caches (1..8).
- SNOOP_TIMEOUT, 15: cycles allowed in COLLECT plus WB_WAIT before forced completion; used only with the timeout macro.

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  local cache presents a bus operation.
- req_ready  out  1  agent can accept; high only in IDLE.
- req_op  in  3  bus op: READ=1, WRITE=2, INVALIDATE=3, RFO=4, NOP=5; other codes are treated as NOP.
- req_tag  in  `TAG_BITS  line tag.
- req_index  in  `INDEX_BITS  line index.
- snp_valid  out  1  one-cycle broadcast strobe to remote agents.
- snp_op  out  3  latched op.
- snp_tag  out  `TAG_BITS  latched tag.
- snp_index  out  `INDEX_BITS  latched index.
- snp_resp_valid  in  NUM_AGENTS  per-agent response strobe.
- snp_resp  in  2*NUM_AGENTS  per-agent result, agent i at [2i+1:2i]: hit=0, hitm=1, nohit=2, 3 is reserved.
- wb_valid  in  1  HITM owner's writeback observed on the bus.
- done_valid  out  1  one-cycle completion strobe.
- done_snoop  out  2  merged result, valid with done_valid.
- timeout_err  out  1  one-cycle strobe coincident with done_valid when completion was forced.

## Operation
- States: IDLE, BCAST, COLLECT, WB_WAIT, RESPOND.
- IDLE: req_ready=1.
  - On req_valid, latch op, tag and index.
  - NOP or invalid op goes to RESPOND with result nohit; there is no broadcast.
  - All other ops go to BCAST.
- BCAST: snp_valid=1 for exactly one cycle.
  - WRITE goes to RESPOND with result nohit and collects no responses.
  - Other ops go to COLLECT, unless all responses arrive in this cycle (see the completion rule below).
- Response capture happens in BCAST and COLLECT.
  - A per-agent received mask sets bit i on snp_resp_valid[i].
  - A repeat response from an already-received agent is ignored.
  - Responses arriving in IDLE, WB_WAIT or RESPOND are ignored.
- Merge priority: any hitm gives hitm; otherwise any hit gives hit; otherwise nohit. Reserved code 3 counts as nohit.
- Completion: when the next-cycle mask is all ones:
  - merged hitm with op READ or RFO goes to WB_WAIT;
  - everything else goes to RESPOND.
  - INVALIDATE receiving hitm reports hitm and does not wait for a writeback.
- WB_WAIT: on wb_valid go to RESPOND with result hitm.
- RESPOND: done_valid=1 and done_snoop=merged result for one cycle, then IDLE. The mask clears on leaving RESPOND.
- Output latches snp_op, snp_tag and snp_index hold their values until the next accept.

## Timing
- Reset values: state IDLE, req_ready=1, snp_valid=0, done_valid=0, done_snoop=nohit (2), timeout_err=0, mask=0, snp_op=NOP, snp_tag=0, snp_index=0.
- Reset asserted mid-operation aborts immediately with no done strobe.
- Control outputs are Moore-decoded from registered state. No combinational path from req_valid to req_ready.
- Accept at edge T0. NOP: done_valid in cycle T0+1.
- WRITE: snp_valid in T0+1, done_valid in T0+2.
- READ, RFO, INVALIDATE:
  - snp_valid in T0+1.
  - Earliest done_valid is T0+2, when all responses arrive in T0+1.
  - Otherwise done_valid comes one cycle after the last response edge, or one cycle after wb_valid.
- wb_valid asserted in the same cycle as the last response is ignored; only WB_WAIT samples it.
- Back-to-back: next accept no earlier than the cycle after RESPOND.

## Configuration
- SNOOP_TIMEOUT_EN defined:
  - A counter clears on entering COLLECT and increments each cycle in COLLECT or WB_WAIT.
  - When it reaches SNOOP_TIMEOUT, missing agents count as nohit, the merged result is reported and the FSM goes to RESPOND.
  - timeout_err pulses with done_valid.
  - A timeout in WB_WAIT reports hitm.
- SNOOP_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; timeout_err is tied to 0.

## Structure
- Bus op codes, snoop codes and FSM state encodings are shared with the MESIF controller and go in defines.v.
- One sub-module, snoop_merge: combinational priority merge of the masked per-agent results into the 2-bit result.

## Test plan
- NOP (op 5) accepted: done_valid at T0+1 with done_snoop=2; snp_valid never asserts.
- READ at tag/index 0x12/0x3:
  - snp_valid at T0+1 with snp_op=1.
  - Agent responses nohit,hit,nohit arrive across cycles T0+1..T0+3.
  - Expect done_snoop=0 one cycle after the last response.
- RFO with agent 1 returning hitm:
  - FSM holds in WB_WAIT for 4 cycles.
  - wb_valid pulse, then done_valid next cycle with done_snoop=1.
- Duplicate response: agent 0 sends hit, then nohit, then agents 1 and 2 send nohit → done_snoop=0. Mid-operation rst_n low in COLLECT → IDLE, req_ready=1, no done_valid.
- SNOOP_TIMEOUT_EN with SNOOP_TIMEOUT=15: READ where agent 2 never responds and agents 0 and 1 return nohit → done_valid with done_snoop=2 and timeout_err=1, exactly 15 cycles after entering COLLECT.
- WRITE: snp_valid one cycle, done_snoop=2 at T0+2; snp_resp_valid asserted in IDLE has no effect on the next request.
